// File: rtl/tl_periph_pkg.sv
// Shared TL-UL types and host identifiers for the peripheral host arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tl_periph_pkg;

   // One-bit host identifier; also the payload of the in-order ID FIFO.
   typedef enum logic {
      HostIf  = 1'b0,
      HostLsu = 1'b1
   } host_id_e;

   // A-channel opcodes.
   localparam logic [2:0] PutFullData   = 3'h0;
   localparam logic [2:0] Get           = 3'h4;

   // D-channel opcodes.
   localparam logic [2:0] AccessAck     = 3'h0;
   localparam logic [2:0] AccessAckData = 3'h1;

   // Host-to-device: A-channel request plus D-channel ready.
   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   // Device-to-host: D-channel response plus A-channel ready.
   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_ord_fifo.sv
// In-order FIFO holding which host owns each outstanding device transaction.
// Latency: write visible at head one cycle after push; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on o_full/o_empty.
module tlul_arb_ord_fifo #(
   parameter int Width = 1,
   parameter int Depth = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [Width-1:0] i_wdata,
   input  logic             i_pop,
   output logic [Width-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastIdx  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   logic [Width-1:0] r_mem [Depth];
   logic [PtrW-1:0]  r_wptr;
   logic [PtrW-1:0]  r_rptr;
   logic [CntW-1:0]  r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == DepthCnt);
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_rdata = r_mem[r_rptr];

   // Storage: write at the tail on an accepted push.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers wrap modulo Depth, which need not be a power of two.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= (r_wptr == LastIdx) ? '0 : r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= (r_rptr == LastIdx) ? '0 : r_rptr + 1'b1;
         end
      end
   end

   // Occupancy: simultaneous push and pop leave it unchanged; never wraps.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/tlul_host_arb.sv
// Merges the IF and LSU TL-UL hosts onto one device port; D responses return in issue order.
// Latency: A-channel forwarded combinationally (zero cycles); D-channel steered combinationally.
// Backpressure: a_ready from device to granted host only; all A traffic stalls while MaxOutstanding are in flight.
// Build option: define TLUL_HOST_ARB_FIXED_PRIO_EN for fixed LSU-over-IF priority instead of round-robin.
module tlul_host_arb
   import tl_periph_pkg::*;
#(
   parameter int MaxOutstanding = 4
) (
   input  logic    clk_i,
   input  logic    rst_i,
   input  tl_h2d_t tl_if_i,
   output tl_d2h_t tl_if_o,
   input  tl_h2d_t tl_lsu_i,
   output tl_d2h_t tl_lsu_o,
   output tl_h2d_t tl_dev_o,
   input  tl_d2h_t tl_dev_i,
   output logic    err_o
);

   host_id_e    r_ptr;
   host_id_e    r_lock_host;
   logic        r_locked;
   logic        r_err;

   host_id_e    w_gnt;
   host_id_e    w_head;
   host_id_e    w_ptr_d;
   host_id_e    w_lock_host_d;
   logic        w_locked_d;
   tl_h2d_t     w_gnt_req;
   logic        w_gnt_vld;
   logic        w_a_vld;
   logic        w_a_rdy;
   logic        w_a_hs;
   logic        w_d_vld;
   logic        w_d_hs;
   logic        w_head_d_rdy;
   logic        w_unexp;
   logic        w_full;
   logic        w_empty;
   logic [0:0]  w_fifo_rdata;

   // Grant selection: a locked grant wins, otherwise pick among valid hosts.
   always_comb begin
      w_gnt = r_ptr;
      if (r_locked) begin
         w_gnt = r_lock_host;
      end else begin
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
         if (tl_lsu_i.a_valid) begin
            w_gnt = HostLsu;
         end else if (tl_if_i.a_valid) begin
            w_gnt = HostIf;
         end
`else
         if (tl_lsu_i.a_valid && !tl_if_i.a_valid) begin
            w_gnt = HostLsu;
         end else if (tl_if_i.a_valid && !tl_lsu_i.a_valid) begin
            w_gnt = HostIf;
         end
`endif
      end
   end

   assign w_gnt_req    = (w_gnt == HostLsu) ? tl_lsu_i : tl_if_i;
   assign w_gnt_vld    = w_gnt_req.a_valid;
   assign w_a_vld      = w_gnt_vld && !w_full && !rst_i;
   assign w_a_rdy      = tl_dev_i.a_ready && !w_full && !rst_i;
   assign w_a_hs       = w_a_vld && tl_dev_i.a_ready;

   assign w_head       = host_id_e'(w_fifo_rdata);
   assign w_head_d_rdy = (w_head == HostLsu) ? tl_lsu_i.d_ready : tl_if_i.d_ready;
   assign w_d_vld      = tl_dev_i.d_valid && !w_empty && !rst_i;
   assign w_d_hs       = w_d_vld && w_head_d_rdy;
   assign w_unexp      = tl_dev_i.d_valid && w_empty;

   // Next arbitration state: hold a stalled grant so the A payload stays stable.
   always_comb begin
      w_ptr_d       = r_ptr;
      w_locked_d    = w_gnt_vld && !w_a_hs;
      w_lock_host_d = w_gnt;
      if (w_a_hs) begin
         w_ptr_d = host_id_e'(~w_gnt);
      end
   end

   // Arbitration and error-pulse registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ptr       <= HostLsu;
         r_locked    <= 1'b0;
         r_lock_host <= HostLsu;
         r_err       <= 1'b0;
      end else begin
         r_ptr       <= w_ptr_d;
         r_locked    <= w_locked_d;
         r_lock_host <= w_lock_host_d;
         r_err       <= w_unexp;
      end
   end

   assign err_o = r_err;

   tlul_arb_ord_fifo #(
      .Width (1),
      .Depth (MaxOutstanding)
   ) u_ord_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_a_hs),
      .i_wdata (w_gnt),
      .i_pop   (w_d_hs),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Port muxing: A to device from the grant, D to the host at the FIFO head.
   always_comb begin
      tl_dev_o         = w_gnt_req;
      tl_dev_o.a_valid = w_a_vld;
      tl_dev_o.d_ready = 1'b0;
      if (!rst_i) begin
         tl_dev_o.d_ready = w_empty ? 1'b1 : w_head_d_rdy;
      end

      tl_if_o          = tl_dev_i;
      tl_if_o.a_ready  = w_a_rdy && (w_gnt == HostIf);
      tl_if_o.d_valid  = w_d_vld && (w_head == HostIf);

      tl_lsu_o         = tl_dev_i;
      tl_lsu_o.a_ready = w_a_rdy && (w_gnt == HostLsu);
      tl_lsu_o.d_valid = w_d_vld && (w_head == HostLsu);
   end

endmodule

// File: tb/tb_tlul_host_arb.sv
`timescale 1ns/1ps
// Bench for the IF/LSU TL-UL host arbiter.
// Latency: checks combinational A/D paths a settle step after each drive.
// Backpressure: exercises device stall, FIFO-full blocking and host d_ready stall.
module tb_tlul_host_arb;
   import tl_periph_pkg::*;

   localparam logic [31:0] IfAddr  = 32'h2000_0040;
   localparam logic [31:0] LsuAddr = 32'h1000_0000;

   logic    clk_i = 1'b0;
   logic    rst_i = 1'b1;
   tl_h2d_t tl_if_i;
   tl_d2h_t tl_if_o;
   tl_h2d_t tl_lsu_i;
   tl_d2h_t tl_lsu_o;
   tl_h2d_t tl_dev_o;
   tl_d2h_t tl_dev_i;
   logic    err_o;

   int       n_checks = 0;
   int       n_pass   = 0;
   host_id_e sb[$];
   host_id_e exp_h;

   typedef struct {
      logic     if_v;
      logic     lsu_v;
      logic     ardy;
      logic     exp_vld;
      host_id_e exp_gnt;
   } vec_t;
   vec_t vt[5];

   tlul_host_arb #(.MaxOutstanding(4)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tl_if_i  (tl_if_i),
      .tl_if_o  (tl_if_o),
      .tl_lsu_i (tl_lsu_i),
      .tl_lsu_o (tl_lsu_o),
      .tl_dev_o (tl_dev_o),
      .tl_dev_i (tl_dev_i),
      .err_o    (err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      tl_if_i.a_valid  = 1'b0;
      tl_lsu_i.a_valid = 1'b0;
      tl_if_i.d_ready  = 1'b1;
      tl_lsu_i.d_ready = 1'b1;
      tl_dev_i         = '0;
      tl_dev_i.a_ready = 1'b1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      idle();
      step();
      step();
      rst_i = 1'b0;
      sb.delete();
      step();
   endtask

   // Returns one response and checks it lands on the host the scoreboard expects.
   task automatic respond(input string tag, input logic [31:0] data);
      host_id_e e;
      tl_dev_i.d_valid  = 1'b1;
      tl_dev_i.d_opcode = AccessAckData;
      tl_dev_i.d_data   = data;
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty, got response 0x%0h, required none", tag, data);
      end else begin
         e = sb.pop_front();
         check($sformatf("%s lsu_d_valid", tag), tl_lsu_o.d_valid, e == HostLsu);
         check($sformatf("%s if_d_valid", tag), tl_if_o.d_valid, e == HostIf);
         check($sformatf("%s d_data", tag), (e == HostLsu) ? tl_lsu_o.d_data : tl_if_o.d_data, data);
         check($sformatf("%s dev_d_ready", tag), tl_dev_o.d_ready, 1);
      end
      step();
      tl_dev_i.d_valid = 1'b0;
   endtask

   initial begin
      tl_if_i            = '0;
      tl_if_i.a_opcode   = Get;
      tl_if_i.a_address  = IfAddr;
      tl_if_i.a_mask     = 4'hF;
      tl_lsu_i           = '0;
      tl_lsu_i.a_opcode  = Get;
      tl_lsu_i.a_address = LsuAddr;
      tl_lsu_i.a_mask    = 4'hF;
      idle();

      vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, HostLsu};
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, HostLsu};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, HostLsu};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, HostLsu};
`else
      vt[1] = '{1'b1, 1'b1, 1'b1, 1'b1, HostIf};
      vt[2] = '{1'b1, 1'b1, 1'b1, 1'b1, HostLsu};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, HostIf};
`endif
      vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, HostLsu};

      // Reset held with every input active: all handshake outputs must be quiet.
      tl_if_i.a_valid  = 1'b1;
      tl_lsu_i.a_valid = 1'b1;
      tl_dev_i.d_valid = 1'b1;
      #2;
      check("rst dev_a_valid", tl_dev_o.a_valid, 0);
      check("rst if_a_ready", tl_if_o.a_ready, 0);
      check("rst lsu_a_ready", tl_lsu_o.a_ready, 0);
      check("rst if_d_valid", tl_if_o.d_valid, 0);
      check("rst lsu_d_valid", tl_lsu_o.d_valid, 0);
      check("rst dev_d_ready", tl_dev_o.d_ready, 0);
      check("rst err", err_o, 0);
      do_reset();

      // LSU alone issues a Get; same-cycle forwarding, response to LSU only.
      tl_lsu_i.a_valid = 1'b1;
      #1;
      check("get dev_a_valid", tl_dev_o.a_valid, 1);
      check("get dev_a_address", tl_dev_o.a_address, LsuAddr);
      check("get dev_a_opcode", tl_dev_o.a_opcode, Get);
      check("get lsu_a_ready", tl_lsu_o.a_ready, 1);
      check("get if_a_ready", tl_if_o.a_ready, 0);
      sb.push_back(HostLsu);
      step();
      tl_lsu_i.a_valid = 1'b0;
      #1;
      check("get idle dev_a_valid", tl_dev_o.a_valid, 0);
      respond("get rsp", 32'hCAFE_0001);

      // Arbitration table: both hosts contend, the fifth row hits a full FIFO.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tl_if_i.a_valid  = vt[i].if_v;
         tl_lsu_i.a_valid = vt[i].lsu_v;
         tl_dev_i.a_ready = vt[i].ardy;
         #1;
         check($sformatf("arb%0d dev_a_valid", i), tl_dev_o.a_valid, vt[i].exp_vld);
         check($sformatf("arb%0d if_a_ready", i), tl_if_o.a_ready,
               vt[i].exp_vld && vt[i].ardy && (vt[i].exp_gnt == HostIf));
         check($sformatf("arb%0d lsu_a_ready", i), tl_lsu_o.a_ready,
               vt[i].exp_vld && vt[i].ardy && (vt[i].exp_gnt == HostLsu));
         if (vt[i].exp_vld) begin
            check($sformatf("arb%0d dev_a_address", i), tl_dev_o.a_address,
                  (vt[i].exp_gnt == HostLsu) ? LsuAddr : IfAddr);
            if (vt[i].ardy) sb.push_back(vt[i].exp_gnt);
         end
         step();
      end
      idle();
      for (int i = 0; i < 4; i++) respond($sformatf("arb rsp%0d", i), 32'hA000_0000 + i);

      // Full FIFO blocks the fifth request until one D handshake frees a slot.
      do_reset();
      tl_lsu_i.d_ready = 1'b0;
      tl_lsu_i.a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("fill%0d lsu_a_ready", i), tl_lsu_o.a_ready, 1);
         sb.push_back(HostLsu);
         step();
      end
      #1;
      check("full lsu_a_ready", tl_lsu_o.a_ready, 0);
      check("full dev_a_valid", tl_dev_o.a_valid, 0);
      tl_dev_i.d_valid = 1'b1;
      tl_dev_i.d_data  = 32'hB000_0000;
      #1;
      check("stall lsu_d_valid", tl_lsu_o.d_valid, 1);
      check("stall dev_d_ready", tl_dev_o.d_ready, 0);
      step();
      tl_lsu_i.d_ready = 1'b1;
      #1;
      check("drain dev_d_ready", tl_dev_o.d_ready, 1);
      check("drain lsu_a_ready", tl_lsu_o.a_ready, 0);
      exp_h = sb.pop_front();
      check("drain lsu_d_valid", tl_lsu_o.d_valid, exp_h == HostLsu);
      step();
      tl_dev_i.d_valid = 1'b0;
      #1;
      check("refill lsu_a_ready", tl_lsu_o.a_ready, 1);
      check("refill dev_a_valid", tl_dev_o.a_valid, 1);
      sb.push_back(HostLsu);
      step();
      tl_lsu_i.a_valid = 1'b0;
      for (int i = 0; i < 4; i++) respond($sformatf("full rsp%0d", i), 32'hB000_0010 + i);

      // Stalled IF grant stays locked while LSU also requests.
      do_reset();
      tl_dev_i.a_ready = 1'b0;
      tl_if_i.a_valid  = 1'b1;
      #1;
      check("lock0 dev_a_valid", tl_dev_o.a_valid, 1);
      check("lock0 dev_a_address", tl_dev_o.a_address, IfAddr);
      check("lock0 if_a_ready", tl_if_o.a_ready, 0);
      step();
      tl_lsu_i.a_valid = 1'b1;
      for (int i = 1; i < 3; i++) begin
         #1;
         check($sformatf("lock%0d dev_a_address", i), tl_dev_o.a_address, IfAddr);
         check($sformatf("lock%0d lsu_a_ready", i), tl_lsu_o.a_ready, 0);
         step();
      end
      tl_dev_i.a_ready = 1'b1;
      #1;
      check("lock hs if_a_ready", tl_if_o.a_ready, 1);
      check("lock hs lsu_a_ready", tl_lsu_o.a_ready, 0);
      check("lock hs dev_a_address", tl_dev_o.a_address, IfAddr);
      sb.push_back(HostIf);
      step();
      tl_if_i.a_valid = 1'b0;
      #1;
      check("unlock dev_a_address", tl_dev_o.a_address, LsuAddr);
      check("unlock lsu_a_ready", tl_lsu_o.a_ready, 1);
      sb.push_back(HostLsu);
      step();
      tl_lsu_i.a_valid = 1'b0;
      respond("lock rsp0", 32'hC000_0000);
      respond("lock rsp1", 32'hC000_0001);

      // In-order return for LSU, IF, LSU, plus push and pop in the same cycle.
      do_reset();
      tl_lsu_i.a_valid = 1'b1;
      step();
      sb.push_back(HostLsu);
      tl_lsu_i.a_valid = 1'b0;
      tl_if_i.a_valid  = 1'b1;
      step();
      sb.push_back(HostIf);
      tl_if_i.a_valid  = 1'b0;
      tl_lsu_i.a_valid = 1'b1;
      step();
      sb.push_back(HostLsu);
      tl_lsu_i.a_valid = 1'b0;
      tl_if_i.a_valid  = 1'b1;
      tl_dev_i.d_valid = 1'b1;
      tl_dev_i.d_data  = 32'hD000_0000;
      #1;
      check("pp if_a_ready", tl_if_o.a_ready, 1);
      exp_h = sb.pop_front();
      check("pp lsu_d_valid", tl_lsu_o.d_valid, exp_h == HostLsu);
      check("pp if_d_valid", tl_if_o.d_valid, exp_h == HostIf);
      sb.push_back(HostIf);
      step();
      tl_if_i.a_valid  = 1'b0;
      tl_dev_i.d_valid = 1'b0;
      tl_lsu_i.a_valid = 1'b1;
      #1;
      check("pp fourth lsu_a_ready", tl_lsu_o.a_ready, 1);
      sb.push_back(HostLsu);
      step();
      #1;
      check("pp full lsu_a_ready", tl_lsu_o.a_ready, 0);
      tl_lsu_i.a_valid = 1'b0;
      for (int i = 0; i < 4; i++) respond($sformatf("ord rsp%0d", i), 32'hD000_0001 + i);

      // Response with nothing in flight: absorbed, no host sees it, one-cycle error.
      do_reset();
      tl_dev_i.d_valid = 1'b1;
      #1;
      check("unexp dev_d_ready", tl_dev_o.d_ready, 1);
      check("unexp if_d_valid", tl_if_o.d_valid, 0);
      check("unexp lsu_d_valid", tl_lsu_o.d_valid, 0);
      check("unexp err early", err_o, 0);
      step();
      tl_dev_i.d_valid = 1'b0;
      #1;
      check("unexp err pulse", err_o, 1);
      step();
      check("unexp err cleared", err_o, 0);

      // Reset with two in flight: outputs drop at once, later responses are unexpected.
      do_reset();
      tl_lsu_i.a_valid = 1'b1;
      step();
      step();
      tl_dev_i.d_valid = 1'b1;
      #1;
      check("mid pre lsu_d_valid", tl_lsu_o.d_valid, 1);
      #2;
      rst_i = 1'b1;
      #1;
      check("mid rst dev_a_valid", tl_dev_o.a_valid, 0);
      check("mid rst lsu_a_ready", tl_lsu_o.a_ready, 0);
      check("mid rst if_a_ready", tl_if_o.a_ready, 0);
      check("mid rst lsu_d_valid", tl_lsu_o.d_valid, 0);
      check("mid rst if_d_valid", tl_if_o.d_valid, 0);
      check("mid rst dev_d_ready", tl_dev_o.d_ready, 0);
      check("mid rst err", err_o, 0);
      step();
      tl_lsu_i.a_valid = 1'b0;
      rst_i = 1'b0;
      sb.delete();
      #1;
      check("post rst lsu_d_valid", tl_lsu_o.d_valid, 0);
      check("post rst dev_d_ready", tl_dev_o.d_ready, 1);
      step();
      tl_dev_i.d_valid = 1'b0;
      #1;
      check("post rst err pulse", err_o, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
